// File: rtl/maze_agent_sequencer_if.sv
// Signal bundle between the maze agent sequencer and the video pipeline:
// binarized video and neighbour flags in, agent pose and status out.
interface maze_agent_sequencer_if;
   logic       video_frame_valid;
   logic       video_line_valid;
   logic       video_data_valid;
   logic       pix_bin;
   logic       nbr_valid;
   logic [3:0] nbr_open;
   logic [9:0] pose_x;
   logic [9:0] pose_y;
   logic [3:0] pose_dir;
   logic [9:0] start_x;
   logic [9:0] end_x;
   logic       maze_defined;
   logic       pose_update;
   logic [9:0] step_cnt;
   logic       done;
   logic       fail;

   modport master (
      output video_frame_valid, video_line_valid, video_data_valid, pix_bin,
      output nbr_valid, nbr_open,
      input  pose_x, pose_y, pose_dir, start_x, end_x,
      input  maze_defined, pose_update, step_cnt, done, fail
   );

   modport slave (
      input  video_frame_valid, video_line_valid, video_data_valid, pix_bin,
      input  nbr_valid, nbr_open,
      output pose_x, pose_y, pose_dir, start_x, end_x,
      output maze_defined, pose_update, step_cnt, done, fail
   );
endinterface

// File: rtl/maze_agent_sequencer.sv
// Frame-level maze agent controller: measures entry/exit columns from the video,
// then moves the agent one step per frame from the window neighbour flags.
module maze_agent_sequencer #(
   parameter int H_ACTIVE  = 702,
   parameter int START_ROW = 15,
   parameter int END_ROW   = 274,
   parameter int STEP_H    = 8,
   parameter int STEP_V    = 4,
   parameter int MAX_STEPS = 1023
) (
   input  logic                    clk,
   input  logic                    reset,
   maze_agent_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {MEASURE, TRACK, DONE_S, FAIL_S} state_t;

   localparam logic [3:0]  DIR_DOWN  = 4'b1000;
   localparam logic [3:0]  DIR_LEFT  = 4'b0100;
   localparam logic [3:0]  DIR_UP    = 4'b0010;
   localparam logic [3:0]  DIR_RIGHT = 4'b0001;
   localparam logic [10:0] STEP_H_W  = 11'(STEP_H);
   localparam logic [10:0] STEP_V_W  = 11'(STEP_V);
   localparam logic [10:0] X_MAX_W   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] END_ROW_W = 11'(END_ROW);
   localparam logic [8:0]  X_MAX_H   = 9'((H_ACTIVE - 1) >> 1);
   localparam logic [9:0]  POSE_Y0   = 10'(START_ROW + 1);
   localparam logic [9:0]  MAX_STEPS_W = 10'(MAX_STEPS);

   state_t           state_q, state_d;
   logic             fv_q, fv_d, lv_q, lv_d, armed_q, armed_d, pix_prev_q, pix_prev_d;
   logic [9:0]       cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
   // Only halves of L/R are kept: the centre is L[9:1] + R[9:1].
   logic [1:0][8:0]  l_q, l_d, r_q, r_d;
   logic [1:0]       l_ok_q, l_ok_d, r_ok_q, r_ok_d;
   logic [9:0]       start_x_q, start_x_d, end_x_q, end_x_d;
   logic [9:0]       pose_x_q, pose_x_d, pose_y_q, pose_y_d, step_cnt_q, step_cnt_d;
   logic [3:0]       pose_dir_q, pose_dir_d, pend_dir_q, pend_dir_d;
   logic             maze_defined_q, maze_defined_d, pose_update_q, pose_update_d;
   logic             done_q, done_d, fail_q, fail_d, pend_q, pend_d;

   logic             frame_fall, fe, line_fall, eff_pend, move_ok;
   logic [1:0]       row_hit;
   logic [3:0]       rev_dir, open_fwd, next_dir, eff_dir;
   logic [10:0]      nx, ny, dx;
   logic [9:0]       step_next;

   for (genvar gi = 0; gi < 2; gi++) begin : g_row
      assign row_hit[gi] = (cnt_v_q == 10'((gi == 0) ? START_ROW : END_ROW));
   end

   // A frame end only counts once an idle gap has been seen since reset.
   assign frame_fall = fv_q & ~bus.video_frame_valid;
   assign fe         = frame_fall & armed_q;
   assign line_fall  = lv_q & ~bus.video_line_valid;
   assign step_next  = step_cnt_q + 10'd1;

   always_comb begin
      rev_dir  = {pose_dir_q[1], pose_dir_q[0], pose_dir_q[3], pose_dir_q[2]};
      open_fwd = bus.nbr_open & ~rev_dir;
      if ((open_fwd & pose_dir_q) != 4'd0) next_dir = pose_dir_q;
      else if (open_fwd[3])                next_dir = DIR_DOWN;
      else if (open_fwd[0])                next_dir = DIR_RIGHT;
      else if (open_fwd[1])                next_dir = DIR_UP;
      else if (open_fwd[2])                next_dir = DIR_LEFT;
      else if (bus.nbr_open != 4'd0)       next_dir = rev_dir;
      else                                 next_dir = 4'd0;

      eff_pend = bus.nbr_valid | pend_q;
      eff_dir  = bus.nbr_valid ? next_dir : pend_dir_q;

      nx      = {1'b0, pose_x_q};
      ny      = {1'b0, pose_y_q};
      move_ok = 1'b1;
      if (eff_dir[3]) begin
         ny      = {1'b0, pose_y_q} + STEP_V_W;
         move_ok = ~ny[10];
      end else if (eff_dir[0]) begin
         nx      = {1'b0, pose_x_q} + STEP_H_W;
         move_ok = (nx <= X_MAX_W);
      end else if (eff_dir[1]) begin
         move_ok = ({1'b0, pose_y_q} >= STEP_V_W);
         ny      = {1'b0, pose_y_q} - STEP_V_W;
      end else begin
         move_ok = ({1'b0, pose_x_q} >= STEP_H_W);
         nx      = {1'b0, pose_x_q} - STEP_H_W;
      end
      dx = (nx >= {1'b0, end_x_q}) ? (nx - {1'b0, end_x_q}) : ({1'b0, end_x_q} - nx);
   end

   always_comb begin
      state_d        = state_q;
      fv_d           = bus.video_frame_valid;
      lv_d           = bus.video_line_valid;
      armed_d        = armed_q | ~bus.video_frame_valid;
      pix_prev_d     = pix_prev_q;
      cnt_h_d        = cnt_h_q;
      cnt_v_d        = cnt_v_q;
      l_d            = l_q;
      r_d            = r_q;
      l_ok_d         = l_ok_q;
      r_ok_d         = r_ok_q;
      start_x_d      = start_x_q;
      end_x_d        = end_x_q;
      pose_x_d       = pose_x_q;
      pose_y_d       = pose_y_q;
      pose_dir_d     = pose_dir_q;
      step_cnt_d     = step_cnt_q;
      maze_defined_d = maze_defined_q;
      pose_update_d  = 1'b0;
      done_d         = done_q;
      fail_d         = fail_q;
      pend_d         = pend_q;
      pend_dir_d     = pend_dir_q;

      if (line_fall)                 cnt_h_d = 10'd0;
      else if (bus.video_data_valid) cnt_h_d = cnt_h_q + 10'd1;
      if (frame_fall)                cnt_v_d = 10'd0;
      else if (line_fall)            cnt_v_d = cnt_v_q + 10'd1;
      if (line_fall)                 pix_prev_d = 1'b0;
      else if (bus.video_data_valid) pix_prev_d = bus.pix_bin;

      if (state_q == MEASURE && armed_q) begin
         for (int i = 0; i < 2; i++) begin
            if (row_hit[i]) begin
               if (bus.video_data_valid && bus.pix_bin && !pix_prev_q && !l_ok_q[i]) begin
                  l_d[i]    = cnt_h_q[9:1];
                  l_ok_d[i] = 1'b1;
               end
               if (bus.video_data_valid && !bus.pix_bin && pix_prev_q) begin
                  r_d[i]    = 9'((cnt_h_q - 10'd1) >> 1);
                  r_ok_d[i] = 1'b1;
               end
               if (line_fall && pix_prev_q) begin
                  r_d[i]    = X_MAX_H;
                  r_ok_d[i] = 1'b1;
               end
            end
         end
      end

      if (state_q == TRACK && bus.nbr_valid) begin
         pend_d     = 1'b1;
         pend_dir_d = next_dir;
      end

      case (state_q)
         MEASURE: begin
            if (fe) begin
               l_ok_d = 2'b00;
               r_ok_d = 2'b00;
               if (&{l_ok_q, r_ok_q}) begin
                  start_x_d      = {1'b0, l_q[0]} + {1'b0, r_q[0]};
                  end_x_d        = {1'b0, l_q[1]} + {1'b0, r_q[1]};
                  pose_x_d       = {1'b0, l_q[0]} + {1'b0, r_q[0]};
                  pose_y_d       = POSE_Y0;
                  pose_dir_d     = DIR_DOWN;
                  maze_defined_d = 1'b1;
                  pend_d         = 1'b0;
                  state_d        = TRACK;
               end
            end
         end
         TRACK: begin
            if (fe && eff_pend) begin
               pend_d     = 1'b0;
               pend_dir_d = 4'd0;
               if (eff_dir == 4'd0 || !move_ok) begin
                  state_d = FAIL_S;
                  fail_d  = 1'b1;
               end else begin
                  pose_dir_d    = eff_dir;
                  pose_x_d      = nx[9:0];
                  pose_y_d      = ny[9:0];
                  step_cnt_d    = step_next;
                  pose_update_d = 1'b1;
                  if (ny >= END_ROW_W && dx <= STEP_H_W) begin
                     state_d = DONE_S;
                     done_d  = 1'b1;
                  end else if (step_next == MAX_STEPS_W) begin
                     state_d = FAIL_S;
                     fail_d  = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MEASURE;       fv_q <= 1'b0;        lv_q <= 1'b0;
         armed_q <= 1'b0;          pix_prev_q <= 1'b0;  cnt_h_q <= 10'd0;
         cnt_v_q <= 10'd0;         l_q <= '0;           r_q <= '0;
         l_ok_q <= 2'b00;          r_ok_q <= 2'b00;     start_x_q <= 10'd0;
         end_x_q <= 10'd0;         pose_x_q <= 10'd0;   pose_y_q <= 10'd0;
         pose_dir_q <= 4'd0;       step_cnt_q <= 10'd0; maze_defined_q <= 1'b0;
         pose_update_q <= 1'b0;    done_q <= 1'b0;      fail_q <= 1'b0;
         pend_q <= 1'b0;           pend_dir_q <= 4'd0;
      end else begin
         state_q <= state_d;       fv_q <= fv_d;        lv_q <= lv_d;
         armed_q <= armed_d;       pix_prev_q <= pix_prev_d; cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;       l_q <= l_d;          r_q <= r_d;
         l_ok_q <= l_ok_d;         r_ok_q <= r_ok_d;    start_x_q <= start_x_d;
         end_x_q <= end_x_d;       pose_x_q <= pose_x_d; pose_y_q <= pose_y_d;
         pose_dir_q <= pose_dir_d; step_cnt_q <= step_cnt_d; maze_defined_q <= maze_defined_d;
         pose_update_q <= pose_update_d; done_q <= done_d; fail_q <= fail_d;
         pend_q <= pend_d;         pend_dir_q <= pend_dir_d;
      end
   end

   assign bus.pose_x       = pose_x_q;
   assign bus.pose_y       = pose_y_q;
   assign bus.pose_dir     = pose_dir_q;
   assign bus.start_x      = start_x_q;
   assign bus.end_x        = end_x_q;
   assign bus.maze_defined = maze_defined_q;
   assign bus.pose_update  = pose_update_q;
   assign bus.step_cnt     = step_cnt_q;
   assign bus.done         = done_q;
   assign bus.fail         = fail_q;
endmodule

// File: tb/tb_maze_agent_sequencer.sv
// Directed bench for maze_agent_sequencer: short synthetic frames for
// acquisition, tiny frames for per-frame tracking steps.
module tb_maze_agent_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   p;
   int   tot;

   always #5 clk = ~clk;

   maze_agent_sequencer_if bus ();

   maze_agent_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("chk %s got=%0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Lines 0..274; only START_ROW (15) and END_ROW (274) carry full 702-pixel rows.
   task automatic send_lines(input int s_lo, input int s_hi, input int e_lo, input int e_hi);
      for (int k = 0; k <= 274; k++) begin
         int n;
         n = (k == 15 || k == 274) ? 702 : 1;
         bus.video_line_valid = 1'b1;
         for (int i = 0; i < n; i++) begin
            bus.video_data_valid = 1'b1;
            if (k == 15)       bus.pix_bin = (i >= s_lo && i <= s_hi);
            else if (k == 274) bus.pix_bin = (i >= e_lo && i <= e_hi);
            else               bus.pix_bin = 1'b0;
            tick();
         end
         bus.video_line_valid = 1'b0;
         bus.video_data_valid = 1'b0;
         bus.pix_bin          = 1'b0;
         tick();
         tick();
      end
   endtask

   task automatic measure_frame(input int s_lo, input int s_hi, input int e_lo, input int e_hi);
      bus.video_frame_valid = 1'b1;
      tick();
      send_lines(s_lo, s_hi, e_lo, e_hi);
      bus.video_frame_valid = 1'b0;
      tick();
      tick();
      tick();
   endtask

   // npul nbr_valid strobes; with coinc the single strobe lands on the frame-end cycle.
   task automatic track_frame(input int npul, input logic [3:0] o1, input logic [3:0] o2,
                              input bit coinc, output int pulses);
      bus.video_frame_valid = 1'b1;
      tick();
      if (npul >= 1 && !coinc) begin
         bus.nbr_valid = 1'b1;
         bus.nbr_open  = o1;
         tick();
         bus.nbr_valid = 1'b0;
         tick();
      end
      if (npul == 2) begin
         bus.nbr_valid = 1'b1;
         bus.nbr_open  = o2;
         tick();
         bus.nbr_valid = 1'b0;
         tick();
      end
      bus.video_frame_valid = 1'b0;
      if (coinc) begin
         bus.nbr_valid = 1'b1;
         bus.nbr_open  = o1;
      end
      tick();
      bus.nbr_valid = 1'b0;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         if (bus.pose_update) pulses++;
         tick();
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.video_frame_valid = 1'b0;
      bus.video_line_valid  = 1'b0;
      bus.video_data_valid  = 1'b0;
      bus.pix_bin           = 1'b0;
      bus.nbr_valid         = 1'b0;
      bus.nbr_open          = 4'd0;
      do_reset();

      check_val("rst_pose_x", bus.pose_x, 0);
      check_val("rst_pose_y", bus.pose_y, 0);
      check_val("rst_dir", bus.pose_dir, 0);
      check_val("rst_start_x", bus.start_x, 0);
      check_val("rst_end_x", bus.end_x, 0);
      check_val("rst_defined", bus.maze_defined, 0);
      check_val("rst_update", bus.pose_update, 0);
      check_val("rst_steps", bus.step_cnt, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_fail", bus.fail, 0);

      // Start row all closed: acquisition must retry.
      measure_frame(1, 0, 400, 421);
      check_val("fe1_defined", bus.maze_defined, 0);
      measure_frame(340, 361, 400, 421);
      check_val("fe2_defined", bus.maze_defined, 1);
      check_val("acq_start_x", bus.start_x, 350);
      check_val("acq_end_x", bus.end_x, 410);
      check_val("acq_pose_x", bus.pose_x, 350);
      check_val("acq_pose_y", bus.pose_y, 16);
      check_val("acq_dir", bus.pose_dir, 8);
      check_val("acq_steps", bus.step_cnt, 0);

      for (int i = 0; i < 3; i++) begin
         track_frame(1, 4'b1001, 4'b0000, 1'b0, p);
         check_val("down_pulse", p, 1);
         check_val("down_y", bus.pose_y, 20 + 4 * i);
         check_val("down_dir", bus.pose_dir, 8);
         check_val("down_steps", bus.step_cnt, i + 1);
      end

      track_frame(1, 4'b0001, 4'b0000, 1'b0, p);
      check_val("right_dir", bus.pose_dir, 1);
      check_val("right_x", bus.pose_x, 358);
      check_val("right_y", bus.pose_y, 28);
      check_val("right_steps", bus.step_cnt, 4);

      track_frame(1, 4'b0100, 4'b0000, 1'b0, p);
      check_val("deadend_dir", bus.pose_dir, 4);
      check_val("deadend_x", bus.pose_x, 350);
      check_val("deadend_steps", bus.step_cnt, 5);

      track_frame(0, 4'b0000, 4'b0000, 1'b0, p);
      check_val("idle_pulse", p, 0);
      check_val("idle_x", bus.pose_x, 350);
      check_val("idle_y", bus.pose_y, 28);
      check_val("idle_steps", bus.step_cnt, 5);

      // Two strobes: only the second (up) decides.
      track_frame(2, 4'b1000, 4'b0010, 1'b0, p);
      check_val("last_pulse", p, 1);
      check_val("last_dir", bus.pose_dir, 2);
      check_val("last_y", bus.pose_y, 24);
      check_val("last_steps", bus.step_cnt, 6);

      track_frame(1, 4'b0011, 4'b0000, 1'b1, p);
      check_val("coinc_pulse", p, 1);
      check_val("coinc_dir", bus.pose_dir, 2);
      check_val("coinc_y", bus.pose_y, 20);
      check_val("coinc_steps", bus.step_cnt, 7);

      track_frame(1, 4'b0000, 4'b0000, 1'b0, p);
      check_val("blocked_pulse", p, 0);
      check_val("blocked_fail", bus.fail, 1);
      check_val("blocked_x", bus.pose_x, 350);
      check_val("blocked_y", bus.pose_y, 20);
      check_val("blocked_steps", bus.step_cnt, 7);
      track_frame(1, 4'b1000, 4'b0000, 1'b0, p);
      check_val("frozen_pulse", p, 0);
      check_val("frozen_y", bus.pose_y, 20);
      check_val("frozen_fail", bus.fail, 1);
      check_val("frozen_done", bus.done, 0);

      // Entry span starts at pixel 0, exit span runs to line end.
      do_reset();
      measure_frame(0, 8, 690, 701);
      check_val("edge_start_x", bus.start_x, 4);
      check_val("edge_end_x", bus.end_x, 695);
      track_frame(1, 4'b0100, 4'b0000, 1'b0, p);
      check_val("xlow_pulse", p, 0);
      check_val("xlow_fail", bus.fail, 1);
      check_val("xlow_x", bus.pose_x, 4);
      check_val("xlow_steps", bus.step_cnt, 0);

      do_reset();
      measure_frame(400, 421, 400, 421);
      check_val("straight_start_x", bus.start_x, 410);
      tot = 0;
      for (int i = 0; i < 64; i++) begin
         track_frame(1, 4'b1000, 4'b0000, 1'b0, p);
         tot += p;
      end
      check_val("straight_pulses", tot, 64);
      check_val("straight_y", bus.pose_y, 272);
      check_val("straight_done_early", bus.done, 0);
      track_frame(1, 4'b1000, 4'b0000, 1'b0, p);
      check_val("exit_pulse", p, 1);
      check_val("exit_y", bus.pose_y, 276);
      check_val("exit_done", bus.done, 1);
      check_val("exit_steps", bus.step_cnt, 65);
      check_val("exit_fail", bus.fail, 0);
      track_frame(1, 4'b1000, 4'b0000, 1'b0, p);
      check_val("done_hold_pulse", p, 0);
      check_val("done_hold_y", bus.pose_y, 276);

      // Reset in the middle of a frame; that frame must not acquire.
      bus.video_frame_valid = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.video_line_valid = 1'b1;
         bus.video_data_valid = 1'b1;
         tick();
         bus.video_line_valid = 1'b0;
         bus.video_data_valid = 1'b0;
         tick();
      end
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_val("midrst_done", bus.done, 0);
      check_val("midrst_defined", bus.maze_defined, 0);
      check_val("midrst_pose_y", bus.pose_y, 0);
      check_val("midrst_steps", bus.step_cnt, 0);
      check_val("midrst_end_x", bus.end_x, 0);
      send_lines(340, 361, 400, 421);
      bus.video_frame_valid = 1'b0;
      tick();
      tick();
      tick();
      check_val("partial_defined", bus.maze_defined, 0);
      measure_frame(340, 361, 400, 421);
      check_val("reacq_defined", bus.maze_defined, 1);
      check_val("reacq_start_x", bus.start_x, 350);

      // Bounce up/down on dead ends until the step budget runs out.
      do_reset();
      measure_frame(400, 421, 400, 421);
      tot = 0;
      for (int s = 0; s < 1022; s++) begin
         track_frame(1, (s % 2 == 0) ? 4'b0010 : 4'b1000, 4'b0000, 1'b0, p);
         tot += p;
      end
      check_val("budget_pulses", tot, 1022);
      check_val("budget_steps", bus.step_cnt, 1022);
      check_val("budget_y", bus.pose_y, 16);
      check_val("budget_fail_early", bus.fail, 0);
      track_frame(1, 4'b0010, 4'b0000, 1'b0, p);
      check_val("budget_last_pulse", p, 1);
      check_val("budget_last_steps", bus.step_cnt, 1023);
      check_val("budget_last_y", bus.pose_y, 12);
      check_val("budget_fail", bus.fail, 1);
      check_val("budget_done", bus.done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/maze_agent_sequencer.md
Name: maze_agent_sequencer

Overview:
- Frame-level controller for the maze path-finder video pipeline.
- Acquires maze entry and exit columns from the first valid frame(s) of binarized video.
- Then steps the agent pose once per frame, using the neighbour-open flags that the window datapath supplies when its scan window is centred on the current pose.
- Drives pose, direction and status to the window datapath and the overlay/draw logic.

Parameters:
- H_ACTIVE, 702, active pixels per line; valid x range is 0..H_ACTIVE-1.
- START_ROW, 15, line used to measure the entry column.
- END_ROW, 274, line used to measure the exit column.
- STEP_H, 8, horizontal pose step in pixels.
- STEP_V, 4, vertical pose step in lines.
- MAX_STEPS, 1023, step budget before the sequencer gives up.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous active-high reset.
- video_frame_valid  in  1  high during frame.
- video_line_valid  in  1  high during line.
- video_data_valid  in  1  pixel strobe.
- pix_bin  in  1  binarized pixel, 1 = open path.
- nbr_valid  in  1  1-cycle strobe: window centred on pose.
- nbr_open  in  4  open flags {down,left,up,right}, sampled on nbr_valid.
- pose_x  out  10  agent column.
- pose_y  out  10  agent line.
- pose_dir  out  4  one-hot {down,left,up,right}.
- start_x  out  10  measured entry column.
- end_x  out  10  measured exit column.
- maze_defined  out  1  acquisition complete.
- pose_update  out  1  1-cycle strobe when the pose changes.
- step_cnt  out  10  steps taken.
- done  out  1  exit reached, sticky.
- fail  out  1  aborted, sticky.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM=MEASURE, counters 0. Reset asserted mid-frame discards all partial state; acquisition restarts at the next frame.
- Counters:
  - cnt_h += 1 on video_data_valid.
  - cnt_h is cleared on the line_valid falling edge; cnt_v += 1 on the same edge.
  - cnt_v is cleared on the frame_valid falling edge (frame end, FE).
  - Both edges are detected with 1-cycle registered copies.
- MEASURE:
  - On line cnt_v==START_ROW, record L = cnt_h of the first 0->1 transition of pix_bin and R = cnt_h of the last 1->0 transition. The same is done on END_ROW.
  - A row whose first pixel is 1 sets L=0. A row still 1 at line end sets R=H_ACTIVE-1.
  - Centre = L[9:1]+R[9:1], truncating.
  - At FE, if both rows produced an edge pair:
    - latch start_x and end_x;
    - set pose=(start_x, START_ROW+1) and pose_dir=down;
    - set maze_defined=1, go to TRACK.
  - Otherwise clear the flags and stay in MEASURE (retry on the next frame).
- TRACK:
  - On nbr_valid, compute next_dir from nbr_open with the reverse of pose_dir masked:
    - pose_dir if it is open;
    - else the first open direction in the order down, right, up, left;
    - if only the reverse is open, next_dir = reverse (dead end).
    - If nbr_open==0, go to FAIL at FE.
  - Only the last nbr_valid in a frame counts.
  - At FE with a decision pending:
    - pose_dir <= next_dir;
    - pose moves by ±STEP_H in x or ±STEP_V in y, per next_dir;
    - step_cnt += 1, pose_update pulses on the FE+1 cycle, the pending flag clears.
  - At FE with no nbr_valid that frame: pose is held, no pulse.
  - nbr_valid coincident with FE is used for that FE.
- Arithmetic:
  - A move whose result would fall outside x 0..H_ACTIVE-1 or y 0..1023 (10-bit wrap) is not applied; the FSM goes to FAIL instead.
  - After a move, if pose_y >= END_ROW and |pose_x-end_x| <= STEP_H: go to DONE, set done=1.
  - If step_cnt==MAX_STEPS after a move and the move did not reach DONE: go to FAIL, set fail=1.
  - DONE takes precedence over the budget check.
- DONE / FAIL: terminal states; pose is frozen and outputs are held until reset.
- video_frame_valid low at power-up (no frame yet) does not count as FE; only a 1->0 transition does.

Test Plan:
- Synthetic 702x288 frame, START_ROW open span 340..361, END_ROW open span 400..421 -> after the 1st FE: start_x=350, end_x=410, maze_defined=1, pose=(350,16), dir=0001_000 one-hot down (4'b1000).
- First frame has START_ROW all 0, second frame is valid -> maze_defined stays 0 after FE1, becomes 1 after FE2.
- TRACK, dir=down, nbr_open=4'b1001 each frame -> pose_y advances by 4 per FE, dir stays down, pose_update pulses once per frame, step_cnt increments.
- dir=down, nbr_open=4'b0001 (right only) -> dir=0001, pose_x += 8. A following nbr_open=4'b0100 (reverse only) -> dir=left, pose_x -= 8.
- nbr_open=0 -> fail=1 after FE, pose frozen. Separately, pose_x=4 heading left -> fail, pose_x stays 4.
- Straight path down to END_ROW with end_x within 8 -> done=1. A reset pulse mid-frame afterwards -> all outputs 0, FSM back to MEASURE.
